// File: rtl/tartaruga_pkg.sv
// Shared core types: ROB index, 32-bit bus and the functional-unit writeback request.
package tartaruga_pkg;

  typedef logic [3:0]  rob_idx_t;
  typedef logic [31:0] bus32_t;

  typedef struct packed {
    rob_idx_t rob_idx;
    bus32_t   result;
    bus32_t   new_pc;
    logic     branch_taken;
  } wb_req_t;

  localparam int WB_NUM_REQ = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered pointer.
// The pointer moves past the winner on advance and returns to 0 on flush.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] pos_idx;
  logic             found;
  int               pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found     = 1'b1;
        grant_idx = pos_idx;
      end
    end
    // Nothing is granted while flushing or held in reset.
    if (found && !flush_i && !rst_i) grant[grant_idx] = 1'b1;
  end

  // Explicit wrap so a non-power-of-two NUM_REQ never lands on an unused index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr_q <= '0;
    else if (flush_i) ptr_q <= '0;
    else if (advance) ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the single ROB writeback port between NUM_REQ functional units.
// Round-robin grant, payload mux, and a one-beat registered output stage.
module rob_wb_arbiter
  import tartaruga_pkg::*;
#(
  parameter  int NUM_REQ   = WB_NUM_REQ,
  parameter  int ROB_IDX_W = $bits(rob_idx_t),
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx_i,
  input  logic [NUM_REQ*32-1:0]        req_result_i,
  input  logic [NUM_REQ*32-1:0]        req_new_pc_i,
  input  logic [NUM_REQ-1:0]           req_branch_taken_i,
  output logic                         wb_valid_o,
  output logic [ROB_IDX_W-1:0]         wb_rob_idx_o,
  output logic [31:0]                  wb_result_o,
  output logic [31:0]                  wb_new_pc_o,
  output logic                         wb_branch_taken_o,
  output logic [SRC_W-1:0]             wb_src_o
);

  // Handshake: a requester raises valid with stable payload and holds both until it
  // sees ready; ready may follow valid combinationally, valid never looks at ready.
  // A beat transfers on the rising edge where valid && ready.

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  wb_req_t            reqs [NUM_REQ];
  wb_req_t            sel;
  wb_req_t            wb_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .req       (req_valid_i),
    .advance   (|grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i] = '{rob_idx:      rob_idx_t'(req_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W]),
                  result:       req_result_i[i*32 +: 32],
                  new_pc:       req_new_pc_i[i*32 +: 32],
                  branch_taken: req_branch_taken_i[i]};
    end
  end

  assign sel         = reqs[grant_idx];
  assign req_ready_o = grant;

  // Payload holds its last value when idle or flushed; only valid drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_q       <= '0;
      wb_src_o   <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
    end else if (|grant) begin
      wb_valid_o <= 1'b1;
      wb_q       <= sel;
      wb_src_o   <= grant_idx;
    end else begin
      wb_valid_o <= 1'b0;
    end
  end

  assign wb_rob_idx_o      = ROB_IDX_W'(wb_q.rob_idx);
  assign wb_result_o       = wb_q.result;
  assign wb_new_pc_o       = wb_q.new_pc;
  assign wb_branch_taken_o = wb_q.branch_taken;

`ifndef SYNTHESIS
  // Two live requests targeting the same ROB entry indicate an upstream bug.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = i + 1; j < NUM_REQ; j++) begin
          assert (!(req_valid_i[i] && req_valid_i[j] && reqs[i].rob_idx == reqs[j].rob_idx))
            else $error("rob_wb_arbiter: duplicate rob index from requesters %0d and %0d", i, j);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed plus randomized bench for rob_wb_arbiter against a queue-based reference model.
module tb_rob_wb_arbiter;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int W  = 2 + IW + 32 + 32 + 1;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_rob_idx;
  logic [N*32-1:0] req_result;
  logic [N*32-1:0] req_new_pc;
  logic [N-1:0]    req_bt;
  logic            wb_valid;
  logic [IW-1:0]   wb_rob_idx;
  logic [31:0]     wb_result;
  logic [31:0]     wb_new_pc;
  logic            wb_bt;
  logic [1:0]      wb_src;

  rob_wb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(IW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_rob_idx_i      (req_rob_idx),
    .req_result_i       (req_result),
    .req_new_pc_i       (req_new_pc),
    .req_branch_taken_i (req_bt),
    .wb_valid_o         (wb_valid),
    .wb_rob_idx_o       (wb_rob_idx),
    .wb_result_o        (wb_result),
    .wb_new_pc_o        (wb_new_pc),
    .wb_branch_taken_o  (wb_bt),
    .wb_src_o           (wb_src)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int fi_count    = 0;

  // Scoreboard: beats expected on the port, plus the last beat shown (for hold checks).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_beat;

  // Requester-side state: a pending request and its payload, held until granted.
  logic          pend  [N];
  logic [IW-1:0] p_idx [N];
  logic [31:0]   p_res [N];
  logic [31:0]   p_pc  [N];
  logic          p_bt  [N];
  int            m_rr;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] wb_obs();
    return {wb_src, wb_rob_idx, wb_result, wb_new_pc, wb_bt};
  endfunction

  // Reference arbitration: first pending requester at or after the pointer, cyclically.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  // Driver tasks
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = pend[i];
      req_rob_idx[i*IW +: IW]  = p_idx[i];
      req_result[i*32 +: 32]   = p_res[i];
      req_new_pc[i*32 +: 32]   = p_pc[i];
      req_bt[i]                = p_bt[i];
    end
  endtask

  task automatic set_req(input int i, input int idx, input logic [31:0] res,
                         input logic [31:0] pc, input logic bt);
    pend[i]  = 1'b1;
    p_idx[i] = IW'(idx);
    p_res[i] = res;
    p_pc[i]  = pc;
    p_bt[i]  = bt;
  endtask

  // One clock: check ready mid-cycle, then the registered beat just after the edge.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = (flush || rst) ? -1 : pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", W'(req_ready), W'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      exp_q.push_back({2'(g), p_idx[g], p_res[g], p_pc[g], p_bt[g]});
      pend[g] = 1'b0;
      m_rr    = (g == N - 1) ? 0 : g + 1;
    end
    if (flush) m_rr = 0;
    #1;
    if (wb_valid === 1'b1 && wb_result === 32'hFEEDFACE) fi_count++;
    if (exp_q.size() > 0) begin
      last_beat = exp_q.pop_front();
      chk("wb_valid_hi", W'(wb_valid), W'(1));
      chk("wb_beat", wb_obs(), last_beat);
    end else begin
      chk("wb_valid_lo", W'(wb_valid), W'(0));
      chk("wb_hold", wb_obs(), last_beat);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_rr      = 0;
    last_beat = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    #1;
    chk("rst_valid", W'(wb_valid), W'(0));
    chk("rst_beat", wb_obs(), W'(0));
    chk("rst_ready", W'(req_ready), W'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 0, '0, '0, 1'b0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    do_reset();

    // Single request straight after reset, then an idle cycle.
    set_req(0, 0, 32'hDEADBEEF, 32'h8, 1'b0);
    cycle();
    cycle();

    // All three held valid: continuous writebacks in rotation.
    flush_cycle();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) set_req(i, i + 1, 32'h100 + i, 32'h200 + i, 1'(i));
      cycle();
    end
    repeat (4) cycle();

    // Pointer rotation: after granting 1, requester 2 beats requester 0.
    flush_cycle();
    set_req(1, 7, 32'h1111, 32'h10, 1'b1);
    cycle();
    set_req(0, 8, 32'h2222, 32'h20, 1'b0);
    set_req(2, 9, 32'h3333, 32'h30, 1'b1);
    repeat (3) cycle();

    // Flush right after a grant: beat still shows once, no ready under flush, 0 wins after.
    set_req(2, 5, 32'hCAFEBABE, 32'h40, 1'b1);
    cycle();
    set_req(0, 6, 32'h4444, 32'h50, 1'b0);
    set_req(2, 10, 32'h5555, 32'h60, 1'b0);
    flush_cycle();
    repeat (3) cycle();

    // Asynchronous reset between edges while a beat is on the port.
    set_req(1, 11, 32'h6666, 32'h70, 1'b1);
    cycle();
    set_req(0, 12, 32'h7777, 32'h80, 1'b0);
    drive();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", W'(wb_valid), W'(0));
    chk("async_rst_beat", wb_obs(), W'(0));
    chk("async_rst_ready", W'(req_ready), W'(0));
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_held_ready", W'(req_ready), W'(0));
    chk("rst_held_valid", W'(wb_valid), W'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();

    // Hold-until-ready: requester 1 waits a cycle and writes back exactly once.
    flush_cycle();
    fi_count = 0;
    set_req(0, 4, 32'h8888, 32'h90, 1'b0);
    set_req(1, 9, 32'hFEEDFACE, 32'hA0, 1'b1);
    repeat (4) cycle();
    chk("feedface_once", W'(fi_count), W'(1));

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      bit dropped;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 3) * 4 + i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      flush   = ($urandom_range(0, 19) == 0);
      dropped = flush && ($urandom_range(0, 1) == 1);
      cycle();
      flush = 1'b0;
      if (dropped) for (int i = 0; i < N; i++) pend[i] = 1'b0;
    end
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
